svo_tmds_sched: RTL and testbench

- Video period scheduler that drives the three TMDS encoder channels.
- Generates raster timing from parameters and decides, per pixel clock, between the control, video-preamble, guard-band and video-data periods.
- Takes pixels from an upstream valid/ready stream and aligns the stream to the frame via a start-of-frame flag.
- Sits between the pixel source and the three encoder instances; the encoders' de/ctrl/din and the guard-code selectors come from here.

---
 rtl/svo_tmds_sched_pkg.sv | 31 +++
 rtl/svo_tmds_sched_raster.sv | 80 ++++++++
 rtl/svo_tmds_sched.sv | 169 ++++++++++++++++
 tb/tb_svo_tmds_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/svo_tmds_sched_pkg.sv
// ---------------------------------------------------------------------------
// svo_tmds_sched_pkg
//   Shared types and constants for the TMDS period scheduler.
//   - period_e    : which TMDS period the current pixel clock belongs to
//   - pix_state_e : pixel-stream alignment state
//   - PREAMBLE_LEN / GUARD_LEN : lengths (in pixel clocks) of the HDMI
//     video preamble and leading guard band that precede each active line
//   - PRE_VIDEO_CTL1/2 : CTL code carried during a video preamble
// ---------------------------------------------------------------------------
package svo_tmds_sched_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_e;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } pix_state_e;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  localparam logic [1:0] PRE_VIDEO_CTL1 = 2'b01;
  localparam logic [1:0] PRE_VIDEO_CTL2 = 2'b00;

endpackage

// File: rtl/svo_tmds_sched_raster.sv
// ---------------------------------------------------------------------------
// svo_raster_cnt
//   Horizontal/vertical raster counters and the position flags derived
//   from them. Line and frame order: active, front porch, sync, back porch.
//
//   clk_i              pixel clock
//   rst_ni             asynchronous active-low reset, counters go to (0,0)
//   h_cnt_o            0 .. H_TOTAL-1
//   v_cnt_o            0 .. V_TOTAL-1, advances when h_cnt_o wraps
//   active_o           position lies inside the active picture
//   hsync_o            raw (active-high) horizontal sync
//   vsync_o            raw (active-high) vertical sync
//   next_line_active_o the line following this one carries active video
// ---------------------------------------------------------------------------
module svo_raster_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          next_line_active_o
);

  // Inclusive bounds so no constant ever needs to hold the value H_TOTAL.
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o  = h_q;
  assign v_cnt_o  = v_q;
  assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  // v_q only moves when h_q wraps to 0, so vsync edges land on h_cnt=0.
  assign vsync_o  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
  // The last blanking line precedes line 0 of the next frame.
  assign next_line_active_o = (v_q < V_ACT_M1) || (v_q == V_LAST);

endmodule

// File: rtl/svo_tmds_sched.sv
// ---------------------------------------------------------------------------
// svo_tmds_sched
//   Video period scheduler feeding three TMDS encoders. Generates raster
//   timing, classifies each pixel clock as control / preamble / guard /
//   video, and aligns an upstream pixel stream to the frame using SOF.
//
//   clk, resetn            pixel clock, asynchronous active-low reset
//   s_valid/s_ready/s_sof/s_data  upstream pixel stream ({r,g,b})
//   out_de                 video data period
//   out_ctrl0              {vsync,hsync} for channel 0 (polarity applied)
//   out_ctrl1, out_ctrl2   {CTL1,CTL0}, {CTL3,CTL2}
//   out_guard              encoders emit video guard-band codes
//   out_data               pixel to encoder din, black when unavailable
//   frame_start            pulse with pixel (0,0)
//   underflow              pulse when a required pixel is missing/misaligned
//   locked                 stream is aligned (state RUN)
//   All outputs except s_ready are registered one cycle after the raster
//   position they describe.
// ---------------------------------------------------------------------------
module svo_tmds_sched
  import svo_tmds_sched_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [23:0] s_data,
  output logic        out_de,
  output logic [1:0]  out_ctrl0,
  output logic [1:0]  out_ctrl1,
  output logic [1:0]  out_ctrl2,
  output logic        out_guard,
  output logic [23:0] out_data,
  output logic        frame_start,
  output logic        underflow,
  output logic        locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] PRE_FIRST = HW'(H_TOTAL - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [HW-1:0] GRD_FIRST = HW'(H_TOTAL - GUARD_LEN);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, hsync, vsync, nla, at_origin;
  period_e       period;

  svo_raster_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .clk_i              (clk),
    .rst_ni             (resetn),
    .h_cnt_o            (h_cnt),
    .v_cnt_o            (v_cnt),
    .active_o           (active),
    .hsync_o            (hsync),
    .vsync_o            (vsync),
    .next_line_active_o (nla)
  );

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // Preamble and guard band only ever occupy the tail of the back porch,
  // so checking active first is just a safety ordering.
  always_comb begin
    period = CTRL;
    if (active) begin
      period = VIDEO;
    end else if (HDMI_MODE && nla && (h_cnt >= GRD_FIRST)) begin
      period = GUARD;
    end else if (HDMI_MODE && nla && (h_cnt >= PRE_FIRST)) begin
      period = PREAMBLE;
    end
  end

  // Stream handshake: a word transfers on a clock edge where s_valid and
  // s_ready are both high; an offered word must be held until it transfers.
  // s_ready is combinational because the decision depends on the word at
  // the head (SOF or not) and on the current raster position.
  pix_state_e  state_q, state_d;
  logic [23:0] data_d;
  logic        uflow_d;

  always_comb begin
    s_ready = 1'b0;
    state_d = state_q;
    data_d  = 24'h0;
    uflow_d = 1'b0;
    case (state_q)
      SYNC: begin
        // Drain until an SOF word reaches the head; keep that word.
        s_ready = ~(s_valid & s_sof);
        if (s_valid && s_sof) state_d = ARMED;
      end
      ARMED: begin
        s_ready = at_origin;
        if (at_origin && s_valid) begin
          data_d  = s_data;
          state_d = RUN;
        end
      end
      RUN: begin
        if (active) begin
          // A mid-frame SOF belongs to the next frame, so leave it queued.
          s_ready = ~(s_sof & ~at_origin);
          if (!s_valid) begin
            uflow_d = 1'b1;
            state_d = SYNC;
          end else if (s_sof && !at_origin) begin
            uflow_d = 1'b1;
            state_d = SYNC;
          end else begin
            data_d = s_data;
            if (at_origin && !s_sof) begin
              uflow_d = 1'b1;
              state_d = SYNC;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= SYNC;
      out_de      <= 1'b0;
      out_guard   <= 1'b0;
      out_ctrl0   <= {~VSYNC_POL, ~HSYNC_POL};
      out_ctrl1   <= 2'b00;
      out_ctrl2   <= 2'b00;
      out_data    <= 24'h0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_de      <= (period == VIDEO);
      out_guard   <= (period == GUARD);
      out_ctrl0   <= {vsync ^ ~VSYNC_POL, hsync ^ ~HSYNC_POL};
      out_ctrl1   <= (period == PREAMBLE) ? PRE_VIDEO_CTL1 : 2'b00;
      out_ctrl2   <= (period == PREAMBLE) ? PRE_VIDEO_CTL2 : 2'b00;
      out_data    <= data_d;
      frame_start <= at_origin;
      underflow   <= uflow_d;
    end
  end

  assign locked = (state_q == RUN);

endmodule

// File: tb/tb_svo_tmds_sched.sv
// ---------------------------------------------------------------------------
// tb_svo_tmds_sched
//   Directed bench for svo_tmds_sched with an 8/2/3/12 x 4/1/1/1 raster
//   (25 x 7). Timing outputs are checked every cycle against the raster
//   definition; stream expectations are written per directed step.
// ---------------------------------------------------------------------------
module tb_svo_tmds_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid, s_sof;
  logic [23:0] s_data;

  logic        s_ready, out_de, out_guard, frame_start, underflow, locked;
  logic [1:0]  out_ctrl0, out_ctrl1, out_ctrl2;
  logic [23:0] out_data;

  logic        d_ready, d_de, d_guard, d_fs, d_uf, d_locked;
  logic [1:0]  d_ctrl0, d_ctrl1, d_ctrl2;
  logic [23:0] d_data;

  int n_vec = 0;
  int n_err = 0;
  int th = 0;
  int tv = 0;
  int pix = 0;
  int de_cnt = 0;
  logic [23:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  svo_tmds_sched #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(12),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof), .s_data(s_data), .out_de(out_de), .out_ctrl0(out_ctrl0),
    .out_ctrl1(out_ctrl1), .out_ctrl2(out_ctrl2), .out_guard(out_guard),
    .out_data(out_data), .frame_start(frame_start), .underflow(underflow),
    .locked(locked)
  );

  svo_tmds_sched #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(12),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b0)
  ) dut_dvi (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(d_ready),
    .s_sof(s_sof), .s_data(s_data), .out_de(d_de), .out_ctrl0(d_ctrl0),
    .out_ctrl1(d_ctrl1), .out_ctrl2(d_ctrl2), .out_guard(d_guard),
    .out_data(d_data), .frame_start(d_fs), .underflow(d_uf),
    .locked(d_locked)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset();
    chk("rst_de", out_de, 1'b0);
    chk("rst_guard", out_guard, 1'b0);
    chk("rst_ctrl0", out_ctrl0, 2'b11);
    chk("rst_ctrl1", out_ctrl1, 2'b00);
    chk("rst_ctrl2", out_ctrl2, 2'b00);
    chk("rst_data", out_data, 24'h0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_locked", locked, 1'b0);
  endtask

  // ---------------- driver ----------------
  // One pixel clock: present a word, check s_ready, clock it, then check
  // every registered output against the position it describes.
  task automatic cycle(input logic v, input logic sof, input logic [23:0] d,
                       input logic e_rdy, input logic push,
                       input logic e_uf, input logic e_lock);
    int ph, pv;
    logic nla, e_pre, e_grd;
    logic [23:0] e_dat;
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    #1;
    chk("s_ready", s_ready, e_rdy);
    if (push) exp_q.push_back(d);
    ph = th;
    pv = tv;
    @(posedge clk);
    #1;
    th = th + 1;
    if (th == 25) begin
      th = 0;
      tv = (tv == 6) ? 0 : tv + 1;
    end
    nla   = (pv < 3) || (pv == 6);
    e_pre = nla && (ph >= 15) && (ph <= 22);
    e_grd = nla && (ph >= 23);
    e_dat = push ? exp_q.pop_front() : 24'h0;
    if (out_de) de_cnt++;
    chk("de", out_de, (ph < 8) && (pv < 4));
    chk("hsync_n", out_ctrl0[0], !((ph >= 10) && (ph < 13)));
    chk("vsync_n", out_ctrl0[1], !(pv == 5));
    chk("ctrl1", out_ctrl1, e_pre ? 2'b01 : 2'b00);
    chk("ctrl2", out_ctrl2, 2'b00);
    chk("guard", out_guard, e_grd);
    chk("frame_start", frame_start, (ph == 0) && (pv == 0));
    chk("out_data", out_data, e_dat);
    chk("underflow", underflow, e_uf);
    chk("locked", locked, e_lock);
    chk("dvi_de", d_de, (ph < 8) && (pv < 4));
    chk("dvi_ctrl0", d_ctrl0, {!(pv == 5), !((ph >= 10) && (ph < 13))});
    chk("dvi_ctrl1", d_ctrl1, 2'b00);
    chk("dvi_guard", d_guard, 1'b0);
  endtask

  function automatic logic is_act(input int h, input int v);
    return (h < 8) && (v < 4);
  endfunction

  // Locked counting stream: head word is index pix, SOF on index 0.
  task automatic run_one();
    if (is_act(th, tv)) begin
      cycle(1'b1, pix == 0, 24'(pix), 1'b1, 1'b1, 1'b0, 1'b1);
      pix = (pix + 1) % 32;
    end else begin
      cycle(1'b1, pix == 0, 24'(pix), 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // SOF word seen in SYNC, held through ARMED, taken at (0,0).
  task automatic lock_on(input logic [23:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    while (!(th == 0 && tv == 0)) cycle(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, d, 1'b1, 1'b1, 1'b0, 1'b1);
    pix = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    #3 resetn = 1'b1;

    // Idle frame: pure timing, no stream.
    de_cnt = 0;
    for (int i = 0; i < 175; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("de_per_frame", de_cnt, 32);

    // Mid-frame start: three junk words dropped, then SOF.
    while (!(th == 5 && tv == 2)) cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 24'hDEAD01, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 24'hDEAD02, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 24'hDEAD03, 1'b1, 1'b0, 1'b0, 1'b0);
    lock_on(24'h112233);

    // Counting frames: rest of this frame plus three full frames.
    for (int i = 0; i < 174 + 3 * 175; i++) run_one();

    // Valid drops at pixel (3,1).
    while (!(th == 3 && tv == 1)) run_one();
    cycle(1'b0, 1'b0, 24'(pix), 1'b1, 1'b0, 1'b1, 1'b0);
    while (pix != 0) begin
      cycle(1'b1, 1'b0, 24'(pix), 1'b1, 1'b0, 1'b0, 1'b0);
      pix = (pix + 1) % 32;
    end
    lock_on(24'h000000);

    // Stray SOF at pixel (5,2): not taken, replayed as next frame's first.
    while (!(th == 5 && tv == 2)) run_one();
    cycle(1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 1'b0);
    lock_on(24'hABCDEF);
    for (int i = 0; i < 40; i++) run_one();

    // Asynchronous reset mid-frame.
    s_valid = 1'b0;
    s_sof   = 1'b0;
    resetn  = 1'b0;
    #1;
    chk_reset();
    @(posedge clk);
    #4 resetn = 1'b1;
    th = 0;
    tv = 0;
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
